// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_fifo : 8N1 UART receiver with a byte FIFO and sticky error flags |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rxd,
  input  logic        rd_en,
  input  logic        clr_err,
  output logic [31:0] rd_data,
  output logic        rx_avail
);

  localparam int c_DIV   = CLK_FREQ_HZ / BAUD_RATE;
  localparam int c_CNT_W = $clog2(c_DIV);
  localparam int c_AW    = $clog2(FIFO_DEPTH);

  localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(c_DIV / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_AW:0]      c_PTR_ONE  = (c_AW + 1)'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic               r_sync1;
  logic               r_sync2;
  state_t             r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_idx;
  logic [7:0]         r_shift;

  logic [c_AW:0]      r_wptr;
  logic [c_AW:0]      r_rptr;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic               r_ovr;
  logic               r_ferr;

  logic       w_rx;
  logic       w_stop_tick;
  logic       w_push;
  logic       w_ferr_set;
  logic       w_empty;
  logic       w_full;
  logic       w_pop;
  logic       w_wr;
  logic       w_ovr_set;
  logic [7:0] w_head;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx = r_sync2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_rx) begin
            r_state <= S_START;
            r_cnt   <= c_CNT_HALF;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            if (!w_rx) begin
              r_state <= S_DATA;
              r_cnt   <= c_CNT_FULL;
              r_idx   <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {w_rx, r_shift[7:1]};
            r_cnt   <= c_CNT_FULL;
            r_idx   <= r_idx + 3'd1;
            if (r_idx == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
          end
        end
        S_STOP: begin
          // Back to IDLE at mid-stop; the line is still high so no false start.
          if (r_cnt == '0) r_state <= S_IDLE;
          else             r_cnt   <= r_cnt - c_CNT_ONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_stop_tick = (r_state == S_STOP) && (r_cnt == '0);
  assign w_push      = w_stop_tick & w_rx;
  assign w_ferr_set  = w_stop_tick & ~w_rx;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_pop     = rd_en & ~w_empty;
  assign w_wr      = w_push & (~w_full | w_pop);
  assign w_ovr_set = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + c_PTR_ONE;
      if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever empty.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[c_AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovr  <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      if (w_ovr_set)    r_ovr <= 1'b1;
      else if (clr_err) r_ovr <= 1'b0;
      if (w_ferr_set)   r_ferr <= 1'b1;
      else if (clr_err) r_ferr <= 1'b0;
    end
  end

  assign w_head   = w_empty ? 8'h00 : r_mem[r_rptr[c_AW-1:0]];
  assign rd_data  = {21'b0, r_ferr, r_ovr, ~w_empty, w_head};
  assign rx_avail = ~w_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_rx_fifo : self-checking bench for uart_rx_fifo (DIV=16, depth 4) |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo;
  localparam int CLK_FREQ_HZ = 16;
  localparam int BAUD_RATE   = 1;
  localparam int FIFO_DEPTH  = 4;
  localparam int DIV         = CLK_FREQ_HZ / BAUD_RATE;

  logic        clk     = 1'b0;
  logic        resetn  = 1'b0;
  logic        rxd     = 1'b1;
  logic        rd_en   = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] rd_data;
  logic        rx_avail;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: received bytes in arrival order plus the two sticky flags.
  logic [7:0] q[$];
  bit         m_ovr  = 1'b0;
  bit         m_ferr = 1'b0;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD_RATE  (BAUD_RATE),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .rxd     (rxd),
    .rd_en   (rd_en),
    .clr_err (clr_err),
    .rd_data (rd_data),
    .rx_avail(rx_avail)
  );

  function automatic logic [31:0] exp_word();
    logic [7:0] h;
    h = (q.size() != 0) ? q[0] : 8'h00;
    return {21'b0, m_ferr, m_ovr, (q.size() != 0), h};
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ok);
    if (!ok)                     m_ferr = 1'b1;
    else if (q.size() < FIFO_DEPTH) q.push_back(b);
    else                         m_ovr = 1'b1;
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit ok);
    @(posedge clk); #1 rxd = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rxd = b[i];
      repeat (DIV) @(posedge clk);
    end
    #1 rxd = ok;
    repeat (DIV) @(posedge clk);
    #1 rxd = 1'b1;
  endtask

  task automatic pop_once();
    @(posedge clk); #1 rd_en = 1'b1;
    @(posedge clk); #1 rd_en = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  task automatic clear_errors();
    @(posedge clk); #1 clr_err = 1'b1;
    @(posedge clk); #1 clr_err = 1'b0;
    m_ovr  = 1'b0;
    m_ferr = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; rxd = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected %h", rd_data, 32'h0); end
    n_checks++;
    if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL reset_rx_avail: got %b expected 0", rx_avail); end
    @(posedge clk); #1 resetn = 1'b1;
    fork
      send_frame(8'hF0, 1'b1);
      begin
        @(posedge clk);
        repeat (88) @(posedge clk);
        #1 resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
      end
    join
    repeat (2 * DIV) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'h0 || rx_avail !== 1'b0) begin
      n_fail++; $display("FAIL reset_midframe: got %h avail %b expected %h avail 0", rd_data, rx_avail, 32'h0);
    end
  endtask

  task automatic test_single();
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (rx_avail !== 1'b0) begin n_fail++; $display("FAIL single_early: rx_avail got %b expected 0 at t0+154", rx_avail); end
        @(negedge clk);
        n_checks++;
        if (rx_avail !== 1'b1 || rd_data !== 32'h155) begin
          n_fail++; $display("FAIL single_latency: got %h avail %b expected %h avail 1 at t0+155", rd_data, rx_avail, 32'h155);
        end
      end
    join
    model_frame(8'h55, 1'b1);
    @(negedge clk);
    n_checks++;
    if (rd_data !== exp_word()) begin n_fail++; $display("FAIL single_hold: got %h expected %h", rd_data, exp_word()); end
    pop_once();
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL single_pop: got %h expected %h", rd_data, 32'h0); end
  endtask

  task automatic test_back_to_back();
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b), 1'b1);
      model_frame(8'(b), 1'b1);
    end
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      n_checks++;
      if (rd_data !== exp_word() || rd_data !== (32'h100 | 32'(b))) begin
        n_fail++; $display("FAIL b2b_pop%0d: got %h expected %h", b, rd_data, exp_word());
      end
      pop_once();
    end
    pop_once();
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'h0 || rx_avail !== 1'b0) begin
      n_fail++; $display("FAIL b2b_empty_read: got %h avail %b expected %h avail 0", rd_data, rx_avail, 32'h0);
    end
  endtask

  task automatic test_overrun();
    for (int b = 0; b < 5; b++) begin
      send_frame(8'hA0 + 8'(b), 1'b1);
      model_frame(8'hA0 + 8'(b), 1'b1);
    end
    @(negedge clk);
    n_checks++;
    if (rd_data[9] !== 1'b1 || rd_data !== exp_word()) begin
      n_fail++; $display("FAIL overrun_flag: got %h expected %h", rd_data, exp_word());
    end
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      n_checks++;
      if (rd_data !== exp_word() || rd_data[7:0] !== 8'hA0 + 8'(b)) begin
        n_fail++; $display("FAIL overrun_pop%0d: got %h expected %h", b, rd_data, exp_word());
      end
      pop_once();
    end
    clear_errors();
    @(negedge clk);
    n_checks++;
    if (rd_data[9] !== 1'b0 || rd_data !== 32'h0) begin
      n_fail++; $display("FAIL overrun_clear: got %h expected %h", rd_data, 32'h0);
    end
  endtask

  task automatic test_full_push_pop();
    for (int b = 0; b < 4; b++) begin
      send_frame(8'hB0 + 8'(b), 1'b1);
      model_frame(8'hB0 + 8'(b), 1'b1);
    end
    fork
      send_frame(8'hB4, 1'b1);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        void'(q.pop_front());
      end
    join
    model_frame(8'hB4, 1'b1);
    for (int b = 1; b <= 4; b++) begin
      @(negedge clk);
      n_checks++;
      if (rd_data !== exp_word() || rd_data !== (32'h100 | 32'(8'hB0 + 8'(b)))) begin
        n_fail++; $display("FAIL fullpp_pop%0d: got %h expected %h", b, rd_data, exp_word());
      end
      pop_once();
    end
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'h400 || rd_data !== exp_word()) begin
      n_fail++; $display("FAIL frame_err: got %h expected %h", rd_data, 32'h400);
    end
    repeat (2 * DIV) @(posedge clk);
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'h53C || rd_data !== exp_word()) begin
      n_fail++; $display("FAIL frame_good_after: got %h expected %h", rd_data, 32'h53C);
    end
    pop_once();
    clear_errors();
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'h0) begin n_fail++; $display("FAIL frame_clear: got %h expected %h", rd_data, 32'h0); end
  endtask

  task automatic test_glitch();
    @(posedge clk); #1 rxd = 1'b0;
    repeat (5) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rd_data !== 32'h0 || rx_avail !== 1'b0) begin
      n_fail++; $display("FAIL glitch: got %h avail %b expected %h avail 0", rd_data, rx_avail, 32'h0);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        logic [7:0] b;
        bit         ok;
        b  = 8'($urandom);
        ok = ($urandom_range(0, 4) != 0);
        send_frame(b, ok);
        model_frame(b, ok);
        @(negedge clk);
        n_checks++;
        if (rd_data !== exp_word()) begin
          n_fail++; $display("FAIL rand_frame r%0d k%0d: got %h expected %h", r, k, rd_data, exp_word());
        end
        if (!ok) repeat (2 * DIV) @(posedge clk);
        else     repeat ($urandom_range(0, 20)) @(posedge clk);
        if ($urandom_range(0, 2) == 0) begin
          pop_once();
          @(negedge clk);
          n_checks++;
          if (rd_data !== exp_word()) begin
            n_fail++; $display("FAIL rand_pop r%0d k%0d: got %h expected %h", r, k, rd_data, exp_word());
          end
        end
      end
      while (q.size() != 0) begin
        pop_once();
        @(negedge clk);
        n_checks++;
        if (rd_data !== exp_word()) begin
          n_fail++; $display("FAIL rand_drain r%0d: got %h expected %h", r, rd_data, exp_word());
        end
      end
      clear_errors();
      @(negedge clk);
      n_checks++;
      if (rd_data !== 32'h0) begin n_fail++; $display("FAIL rand_clear r%0d: got %h expected %h", r, rd_data, 32'h0); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_full_push_pop();
    test_frame_error();
    test_glitch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
